sp_ram_arbiter: RTL and testbench

//  Shares one single-port RAM (sp_ram: we/re/addr/data_in/data_out) between two requesters.

---
 rtl/sp_ram_arb_pkg.sv | 6 +
 rtl/sp_ram_arb_pick.sv | 37 +++
 rtl/sp_ram_arbiter.sv | 116 +++++++++++
 tb/tb_sp_ram_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the two-port single-port-RAM arbiter.
package sp_ram_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} arb_state_t;
    typedef logic port_id_t;
    localparam int NUM_REQ = 2;
endpackage

// File: rtl/sp_ram_arb_pick.sv
// Combinational 2-way grant select.
// Build option: SP_RAM_ARB_FIXED_PRIO_EN selects fixed priority (port0 always
// wins contention); otherwise round-robin on last_grant.
module sp_ram_arb_pick
    import sp_ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic               i_last_grant,
    output logic               o_gnt_id,
    output logic               o_gnt_any
);

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    // last_grant has no role when priority is fixed.
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;

    // Port0 wins whenever it is valid; port1 only when alone.
    always_comb begin
        o_gnt_any = |i_req_valid;
        o_gnt_id  = ~i_req_valid[0];
    end
`else
    // Round-robin: on contention, the port that did not win last time goes.
    always_comb begin
        o_gnt_any = |i_req_valid;
        o_gnt_id  = 1'b0;
        case (i_req_valid)
            2'b01:   o_gnt_id = 1'b0;
            2'b10:   o_gnt_id = 1'b1;
            2'b11:   o_gnt_id = ~i_last_grant;
            default: o_gnt_id = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between two valid/ready requesters.
// One transaction in flight at a time; RAM pins are driven from registers.
// Build option: SP_RAM_ARB_FIXED_PRIO_EN (see sp_ram_arb_pick).
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [1:0]            i_req_we,
    input  logic [2*ADDR_W-1:0]   i_req_addr,
    input  logic [2*DATA_W-1:0]   i_req_wdata,
    output logic [1:0]            o_rsp_valid,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_ram_we,
    output logic                  o_ram_re,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic [DATA_W-1:0]     o_ram_data_in,
    input  logic [DATA_W-1:0]     i_ram_data_out
);

    arb_state_t          r_state, w_next_state;
    port_id_t            r_last_grant, r_owner;
    logic                w_gnt_id, w_gnt_any, w_hs;
    logic [1:0]          w_req_ready;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    logic                r_ram_we, r_ram_re;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_data_in;
    logic [1:0]          r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;

    sp_ram_arb_pick u_pick (
        .i_req_valid  (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_gnt_id     (w_gnt_id),
        .o_gnt_any    (w_gnt_any)
    );

    // Mux the granted port's command.
    assign w_sel_we    = w_gnt_id ? i_req_we[1] : i_req_we[0];
    assign w_sel_addr  = w_gnt_id ? i_req_addr[2*ADDR_W-1:ADDR_W] : i_req_addr[ADDR_W-1:0];
    assign w_sel_wdata = w_gnt_id ? i_req_wdata[2*DATA_W-1:DATA_W] : i_req_wdata[DATA_W-1:0];

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next state and ready: only the granted port sees ready, only in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = '0;
        w_hs         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_any) begin
                    w_req_ready[w_gnt_id] = 1'b1;
                    w_hs                  = 1'b1;
                    w_next_state          = ISSUE;
                end
            end
            ISSUE:   w_next_state = r_ram_we ? IDLE : RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Command capture, RAM strobes for one cycle, read response capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ram_we      <= 1'b0;
            r_ram_re      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data_in <= '0;
            r_rsp_valid   <= '0;
            r_rsp_rdata   <= '0;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
        end else begin
            r_rsp_valid <= '0;
            if (w_hs) begin
                r_ram_we      <= w_sel_we;
                r_ram_re      <= ~w_sel_we;
                r_ram_addr    <= w_sel_addr;
                r_ram_data_in <= w_sel_wdata;
                r_owner       <= w_gnt_id;
                r_last_grant  <= w_gnt_id;
            end else if (r_state == ISSUE) begin
                r_ram_we <= 1'b0;
                r_ram_re <= 1'b0;
            end
            if (r_state == RESP) begin
                r_rsp_rdata          <= i_ram_data_out;
                r_rsp_valid[r_owner] <= 1'b1;
            end
        end
    end

    assign o_req_ready   = w_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_ram_we      = r_ram_we;
    assign o_ram_re      = r_ram_re;
    assign o_ram_addr    = r_ram_addr;
    assign o_ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter with a behavioural single-port RAM.
module tb_sp_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic [1:0]    m;
        logic [DW-1:0] d;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          pv [2] = '{1'b0, 1'b0};
    logic          pwe[2] = '{1'b0, 1'b0};
    logic [AW-1:0] pa [2] = '{'0, '0};
    logic [DW-1:0] pd [2] = '{'0, '0};

    logic [1:0]      req_valid, req_ready, req_we, rsp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, ram_data_in, ram_dout;
    logic            ram_we, ram_re;
    logic [AW-1:0]   ram_addr;

    assign req_valid = {pv[1], pv[0]};
    assign req_we    = {pwe[1], pwe[0]};
    assign req_addr  = {pa[1], pa[0]};
    assign req_wdata = {pd[1], pd[0]};

    sp_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_ram_we       (ram_we),
        .o_ram_re       (ram_re),
        .o_ram_addr     (ram_addr),
        .o_ram_data_in  (ram_data_in),
        .i_ram_data_out (ram_dout)
    );

    // Behavioural sp_ram: read data valid the cycle after re is sampled.
    logic [DW-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data_in;
        if (ram_re) ram_dout <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    rsp_t exp_rsp[$];
    int   exp_gnt[$];
    int   rd_hs_cyc[$];
    int   hs_log[$];
    int   rsp_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
    endtask

    // Monitor: invariants every cycle, RAM-op check, response and grant scoreboard.
    initial begin
        logic          op_pend;
        logic          op_we;
        logic [AW-1:0] op_addr;
        logic [DW-1:0] op_data;
        logic [1:0]    hs;
        int            g;
        rsp_t          e;
        op_pend = 1'b0;
        op_we = 1'b0; op_addr = '0; op_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_hs_cyc.delete();
                op_pend = 1'b0;
            end else begin
                chk("we_re_exclusive", 32'(ram_we && ram_re), 0);
                chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
                chk("rsp_onehot0", 32'($onehot0(rsp_valid)), 1);
                if (op_pend) begin
                    chk("op_we", 32'(ram_we), 32'(op_we));
                    chk("op_re", 32'(ram_re), 32'(!op_we));
                    chk("op_addr", 32'(ram_addr), 32'(op_addr));
                    chk("op_data", 32'(ram_data_in), 32'(op_data));
                    op_pend = 1'b0;
                end
                if (rsp_valid != 2'b00) begin
                    rsp_log.push_back(cyc);
                    if (exp_rsp.size() == 0) fail_now("unexpected_rsp");
                    else begin
                        e = exp_rsp.pop_front();
                        chk("rsp_owner", 32'(rsp_valid), 32'(e.m));
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
                    end
                    if (rd_hs_cyc.size() == 0) fail_now("rsp_without_read");
                    else chk("rsp_latency", 32'(cyc - rd_hs_cyc.pop_front()), 3);
                end
                hs = req_valid & req_ready;
                if (hs != 2'b00) begin
                    g = hs[1] ? 1 : 0;
                    hs_log.push_back(cyc);
                    if (exp_gnt.size() == 0) fail_now("unexpected_grant");
                    else chk("grant_port", 32'(g), 32'(exp_gnt.pop_front()));
                    op_pend = 1'b1;
                    op_we   = pwe[g];
                    op_addr = pa[g];
                    op_data = pd[g];
                    if (!pwe[g]) rd_hs_cyc.push_back(cyc);
                end
            end
        end
    end

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a command on port p and hold it until accepted (bounded wait).
    task automatic drive(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pv[p] = 1'b1; pwe[p] = we; pa[p] = a; pd[p] = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                @(posedge clk); #1;
                pv[p] = 1'b0;
                return;
            end
        end
        pv[p] = 1'b0;
        fail_now("accept_timeout");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_re", 32'(ram_re), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_din", 32'(ram_data_in), 0);
        step(1);

        // 1: port0 write then read, plus address range ends
        exp_gnt.push_back(0);
        drive(0, 1'b1, 4'd3, 8'hA5);
        exp_gnt.push_back(0); exp_rsp.push_back('{2'b01, 8'hA5});
        drive(0, 1'b0, 4'd3, 8'h00);
        exp_gnt.push_back(1);
        drive(1, 1'b1, 4'd15, 8'hFF);
        exp_gnt.push_back(1);
        drive(1, 1'b1, 4'd0, 8'h5A);
        exp_gnt.push_back(0); exp_rsp.push_back('{2'b01, 8'hFF});
        drive(0, 1'b0, 4'd15, 8'h00);
        exp_gnt.push_back(1); exp_rsp.push_back('{2'b10, 8'h5A});
        drive(1, 1'b0, 4'd0, 8'h00);
        step(4);

        // 2: contention right after reset, port0 first
        do_reset();
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        fork
            drive(0, 1'b1, 4'd1, 8'h11);
            drive(1, 1'b1, 4'd2, 8'h22);
        join
        exp_gnt.push_back(0); exp_rsp.push_back('{2'b01, 8'h11});
        drive(0, 1'b0, 4'd1, 8'h00);
        exp_gnt.push_back(1); exp_rsp.push_back('{2'b10, 8'h22});
        drive(1, 1'b0, 4'd2, 8'h00);
        step(4);

        // 3: both ports stream reads
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++) begin
            exp_gnt.push_back(0); exp_rsp.push_back('{2'b01, 8'h11});
        end
        for (int i = 0; i < 3; i++) begin
            exp_gnt.push_back(1); exp_rsp.push_back('{2'b10, 8'h22});
        end
`else
        for (int i = 0; i < 3; i++) begin
            exp_gnt.push_back(0); exp_rsp.push_back('{2'b01, 8'h11});
            exp_gnt.push_back(1); exp_rsp.push_back('{2'b10, 8'h22});
        end
`endif
        fork
            begin
                for (int i = 0; i < 3; i++) drive(0, 1'b0, 4'd1, 8'h00);
            end
            begin
                for (int j = 0; j < 3; j++) drive(1, 1'b0, 4'd2, 8'h00);
            end
        join
        step(4);

        // 4: back-to-back reads on one port
        hs_log.delete(); rsp_log.delete();
        exp_gnt.push_back(0); exp_rsp.push_back('{2'b01, 8'hA5});
        exp_gnt.push_back(0); exp_rsp.push_back('{2'b01, 8'h11});
        drive(0, 1'b0, 4'd3, 8'h00);
        drive(0, 1'b0, 4'd1, 8'h00);
        step(4);
        if (hs_log.size() >= 2 && rsp_log.size() >= 1) begin
            chk("b2b_hs_spacing", 32'(hs_log[1] - hs_log[0]), 3);
            chk("b2b_hs_with_rsp", 32'(rsp_log[0]), 32'(hs_log[1]));
        end else fail_now("b2b_missing_events");

        // 5: reset during the ISSUE cycle of a read
        exp_gnt.push_back(0);
        drive(0, 1'b0, 4'd2, 8'h00);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ram_we", 32'(ram_we), 0);
        chk("midrst_ram_re", 32'(ram_re), 0);
        chk("midrst_ram_addr", 32'(ram_addr), 0);
        chk("midrst_ram_din", 32'(ram_data_in), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_rdata", 32'(rsp_rdata), 0);
        step(5);
        exp_gnt.push_back(1); exp_rsp.push_back('{2'b10, 8'hA5});
        drive(1, 1'b0, 4'd3, 8'h00);
        step(6);

        chk("rsp_queue_drained", 32'(exp_rsp.size()), 0);
        chk("gnt_queue_drained", 32'(exp_gnt.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
